mips_multicycle_core: RTL

- Next-generation MIPS core: replaces the single-cycle datapath with a multi-cycle FSM-sequenced datapath.
- Internal state: 32x32 register file, ALU, IR/MDR/A/B/ALUOut holding registers, PC.
- One unified external memory port with a req/ready handshake, so instruction and data accesses share memory with variable latency.
- Adds fault detection (illegal instruction, misaligned access) with a sticky halt.

---
 rtl/mips_multicycle_core.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_core.sv
// rtl/mips_multicycle_core.sv - multi-cycle MIPS subset core with unified memory port and fault halt
//
// Purpose: FSM-sequenced MIPS datapath (FETCH/DECODE/EXEC/MEM/WB/HALT) that
// shares one req/ready memory port between instruction and data accesses.
// Illegal encodings and misaligned lw/sw stop the core with a sticky halt.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-high reset
//   mem_req      memory request valid
//   mem_we       1 = write, 0 = read (valid with mem_req)
//   mem_addr     byte address of the word access
//   mem_wdata    store data
//   mem_rdata    read data, taken on the edge where mem_req & mem_ready
//   mem_ready    memory completes the current request this cycle
//   pc_out       PC of the instruction in flight
//   retire       one-cycle pulse in the last cycle of each instruction
//   halted       sticky fault halt
//   fault_cause  00 none, 01 illegal instruction, 10 misaligned load/store

module mips_multicycle_core #(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       pc_out,
  output logic              retire,
  output logic              halted,
  output logic [1:0]        fault_cause
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  state_t            state, next_state;
  logic              started;
  logic [31:0]       pc, npc, ir, mdr, a, b, alu_out;
  logic [31:0][31:0] rf;
  logic [1:0]        cause;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, dest;
  logic [31:0] imm_sext, r_result, eff_addr;
  logic        is_r, is_addi, is_lw, is_sw, is_beq, is_j, legal, misaligned;

  assign op       = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign imm_sext = {{16{ir[15]}}, ir[15:0]};

  assign is_r    = (op == OP_RTYPE);
  assign is_addi = (op == OP_ADDI);
  assign is_lw   = (op == OP_LW);
  assign is_sw   = (op == OP_SW);
  assign is_beq  = (op == OP_BEQ);
  assign is_j    = (op == OP_J);
  assign dest    = is_r ? rd : rt;

  always_comb begin
    legal = 1'b0;
    if (is_r) begin
      legal = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
              (funct == FN_OR)  || (funct == FN_SLT);
    end else begin
      legal = is_addi || is_lw || is_sw || is_beq || is_j;
    end
  end

  always_comb begin
    r_result = '0;
    case (funct)
      FN_ADD:  r_result = a + b;
      FN_SUB:  r_result = a - b;
      FN_AND:  r_result = a & b;
      FN_OR:   r_result = a | b;
      FN_SLT:  r_result = {31'b0, ($signed(a) < $signed(b))};
      default: r_result = '0;
    endcase
  end

  assign eff_addr   = a + imm_sext;
  assign misaligned = (eff_addr[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  // The first fetch waits one cycle after reset release (started=0) so the
  // memory port is idle for as long as reset is asserted.
  always_comb begin
    next_state = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    retire     = 1'b0;
    case (state)
      FETCH: begin
        if (started) begin
          mem_req  = 1'b1;
          mem_addr = pc[ADDR_W-1:0];
          if (mem_ready) next_state = DECODE;
        end
      end
      DECODE: next_state = legal ? EXEC : HALT;
      EXEC: begin
        if (is_beq || is_j) begin
          retire     = 1'b1;
          next_state = FETCH;
        end else if (is_lw || is_sw) begin
          next_state = misaligned ? HALT : MEM;
        end else begin
          next_state = WB;
        end
      end
      MEM: begin
        mem_req   = 1'b1;
        mem_we    = is_sw;
        mem_addr  = alu_out[ADDR_W-1:0];
        mem_wdata = b;
        if (mem_ready) begin
          if (is_sw) begin
            retire     = 1'b1;
            next_state = FETCH;
          end else begin
            next_state = WB;
          end
        end
      end
      WB: begin
        retire     = 1'b1;
        next_state = FETCH;
      end
      HALT:    next_state = HALT;
      default: next_state = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      started <= 1'b0;
      pc      <= RESET_PC;
      npc     <= '0;
      ir      <= '0;
      mdr     <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      rf      <= '0;
      cause   <= 2'b00;
    end else begin
      started <= 1'b1;
      case (state)
        FETCH: begin
          if (started && mem_ready) begin
            ir  <= mem_rdata;
            npc <= pc + 32'd4;
          end
        end
        DECODE: begin
          a       <= rf[rs];
          b       <= rf[rt];
          alu_out <= npc + {imm_sext[29:0], 2'b00};
          if (!legal) cause <= 2'b01;
        end
        EXEC: begin
          if (is_r) begin
            alu_out <= r_result;
          end else if (is_addi || is_lw || is_sw) begin
            alu_out <= eff_addr;
            if ((is_lw || is_sw) && misaligned) cause <= 2'b10;
          end else if (is_beq) begin
            pc <= (a == b) ? alu_out : npc;
          end else if (is_j) begin
            pc <= {npc[31:28], ir[25:0], 2'b00};
          end
        end
        MEM: begin
          if (mem_ready) begin
            if (is_sw) pc  <= npc;
            else       mdr <= mem_rdata;
          end
        end
        WB: begin
          // r0 is never written, so it reads as zero forever.
          if (dest != 5'd0) rf[dest] <= is_lw ? mdr : alu_out;
          pc <= npc;
        end
        default: ;
      endcase
    end
  end

  assign pc_out      = pc;
  assign halted      = (state == HALT);
  assign fault_cause = cause;

endmodule
